// File: rtl/aes_pkg.sv
// Shared definitions for the AES command sequencer: sequencer states, the AES
// slave register map and control/status bit positions, and the latched command.
package aes_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_CFG,
        WR_KEY,
        WR_INIT,
        SETTLE_I,
        POLL_I,
        WR_BLK,
        WR_NEXT,
        SETTLE_N,
        POLL_N,
        RD_RES,
        OUT
    } aes_seq_state_e;

    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
    localparam logic [7:0] ADDR_KEY0    = 8'h10;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [7:0] ADDR_RESULT0 = 8'h30;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_NEXT_BIT    = 1;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    localparam logic [31:0] CTRL_INIT_VAL = 32'h1 << CTRL_INIT_BIT;
    localparam logic [31:0] CTRL_NEXT_VAL = 32'h1 << CTRL_NEXT_BIT;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] block;
        logic         encdec;
    } aes_cmd_t;

    // Word 0 of a 128-bit value sits in bits [127:96].
    function automatic int word_lsb(input logic [1:0] idx);
        return 32 * (3 - int'(idx));
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] idx);
        return v[word_lsb(idx) +: 32];
    endfunction

endpackage

// File: rtl/aes_seq_bus_if.sv
// Combinational encoder from sequencer state and word index to the AES slave
// port signals: exactly one access per cycle in bus states, cs=0 elsewhere.
module aes_seq_bus_if
    import aes_pkg::*;
(
    input  aes_seq_state_e state,
    input  logic [1:0]     idx,
    input  aes_cmd_t       cmd,
    output logic           cs,
    output logic           we,
    output logic [7:0]     addr,
    output logic [31:0]    wdata
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        cs    = 1'b0;
        we    = 1'b0;
        addr  = 8'h00;
        wdata = 32'h0;
        unique case (state)
            WR_CFG: begin
                cs    = 1'b1;
                we    = 1'b1;
                addr  = ADDR_CONFIG;
                wdata = {31'b0, cmd.encdec};
            end
            WR_KEY: begin
                cs    = 1'b1;
                we    = 1'b1;
                addr  = ADDR_KEY0 + {6'b0, idx};
                wdata = get_word(cmd.key, idx);
            end
            WR_INIT: begin
                cs    = 1'b1;
                we    = 1'b1;
                addr  = ADDR_CTRL;
                wdata = CTRL_INIT_VAL;
            end
            WR_BLK: begin
                cs    = 1'b1;
                we    = 1'b1;
                addr  = ADDR_BLOCK0 + {6'b0, idx};
                wdata = get_word(cmd.block, idx);
            end
            WR_NEXT: begin
                cs    = 1'b1;
                we    = 1'b1;
                addr  = ADDR_CTRL;
                wdata = CTRL_NEXT_VAL;
            end
            POLL_I, POLL_N: begin
                cs    = 1'b1;
                addr  = ADDR_STATUS;
            end
            RD_RES: begin
                cs    = 1'b1;
                addr  = ADDR_RESULT0 + {6'b0, idx};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Bus-master front end for the memory-mapped AES core: one command in, one
// 128-bit result out. Define AES_SEQ_KEY_CACHE_EN to skip key reloads on repeats.
module aes_cmd_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned POLL_TIMEOUT  = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [127:0] cmd_key_i,
    input  logic [127:0] cmd_block_i,
    input  logic         cmd_encdec_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [127:0] res_data_o,
    output logic         aes_cs_o,
    output logic         aes_we_o,
    output logic [7:0]   aes_addr_o,
    output logic [31:0]  aes_wdata_o,
    input  logic [31:0]  aes_rdata_i,
    output logic         busy_o,
    output logic         err_o,
    input  logic         err_clr_i
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] POLL_LAST   = 16'(POLL_TIMEOUT - 1);

    aes_seq_state_e state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    cnt_q, cnt_d;
    aes_cmd_t       cmd_q;
    logic [127:0]   res_q;
    logic           res_valid_q;
    logic           cmd_ready_q;
    logic           err_q;
    logic           cmd_take;
    logic           timeout;
    logic           key_hit;

    logic status_ready;
    logic status_valid;
    assign status_ready = aes_rdata_i[STATUS_READY_BIT];
    assign status_valid = aes_rdata_i[STATUS_VALID_BIT];

`ifdef AES_SEQ_KEY_CACHE_EN
    logic [127:0] last_key_q;
    logic         last_encdec_q;
    logic         key_loaded_q;
    logic         key_store;

    assign key_hit   = key_loaded_q && (cmd_key_i == last_key_q) && (cmd_encdec_i == last_encdec_q);
    assign key_store = (state_q == POLL_I) && (state_d == WR_BLK);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_loaded_q <= 1'b0;
        end else if (timeout) begin
            key_loaded_q <= 1'b0;
        end else if (key_store) begin
            key_loaded_q <= 1'b1;
        end
    end

    // NOTE: the cached key needs no reset; key_loaded_q qualifies every use of it.
    always_ff @(posedge clk_i) begin
        if (key_store) begin
            last_key_q    <= cmd_q.key;
            last_encdec_q <= cmd_q.encdec;
        end
    end
`else
    assign key_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        cmd_take = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_take = 1'b1;
                    idx_d    = 2'd0;
                    state_d  = key_hit ? WR_BLK : WR_CFG;
                end
            end
            WR_CFG: begin
                idx_d   = 2'd0;
                state_d = WR_KEY;
            end
            WR_KEY: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = WR_INIT;
            end
            WR_INIT: begin
                cnt_d   = 16'd0;
                state_d = (SETTLE_CYCLES == 0) ? POLL_I : SETTLE_I;
            end
            SETTLE_I, SETTLE_N: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = (state_q == SETTLE_I) ? POLL_I : POLL_N;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            POLL_I, POLL_N: begin
                // Init only needs ready; next must also report a valid result.
                if (status_ready && (state_q == POLL_I || status_valid)) begin
                    idx_d   = 2'd0;
                    state_d = (state_q == POLL_I) ? WR_BLK : RD_RES;
                end else if (cnt_q == POLL_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WR_BLK: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = WR_NEXT;
            end
            WR_NEXT: begin
                cnt_d   = 16'd0;
                state_d = (SETTLE_CYCLES == 0) ? POLL_N : SETTLE_N;
            end
            RD_RES: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = OUT;
            end
            OUT: begin
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            cmd_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            res_valid_q <= (state_d == OUT);
            cmd_ready_q <= (state_d == IDLE);
            if (cmd_take) begin
                cmd_q <= '{key: cmd_key_i, block: cmd_block_i, encdec: cmd_encdec_i};
            end
            if (state_q == RD_RES) begin
                res_q[word_lsb(idx_q) +: 32] <= aes_rdata_i;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    aes_seq_bus_if u_bus_if (
        .state (state_q),
        .idx   (idx_q),
        .cmd   (cmd_q),
        .cs    (aes_cs_o),
        .we    (aes_we_o),
        .addr  (aes_addr_o),
        .wdata (aes_wdata_o)
    );

    assign cmd_ready_o = cmd_ready_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer against a behavioural AES slave stub
// that knows the FIPS-197 AES-128 example vector.
module tb_aes_cmd_sequencer;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

`ifdef AES_SEQ_KEY_CACHE_EN
    localparam int EXP_CFG_REPEAT = 0;
    localparam int EXP_KEY_REPEAT = 0;
    localparam int EXP_INIT_REPEAT = 0;
`else
    localparam int EXP_CFG_REPEAT = 1;
    localparam int EXP_KEY_REPEAT = 4;
    localparam int EXP_INIT_REPEAT = 1;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [127:0] cmd_key_i;
    logic [127:0] cmd_block_i;
    logic         cmd_encdec_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [127:0] res_data_o;
    logic         aes_cs_o;
    logic         aes_we_o;
    logic [7:0]   aes_addr_o;
    logic [31:0]  aes_wdata_o;
    logic [31:0]  aes_rdata_i;
    logic         busy_o;
    logic         err_o;
    logic         err_clr_i;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk_i = ~clk_i;

    aes_cmd_sequencer #(
        .SETTLE_CYCLES (3),
        .POLL_TIMEOUT  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_key_i    (cmd_key_i),
        .cmd_block_i  (cmd_block_i),
        .cmd_encdec_i (cmd_encdec_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .aes_cs_o     (aes_cs_o),
        .aes_we_o     (aes_we_o),
        .aes_addr_o   (aes_addr_o),
        .aes_wdata_o  (aes_wdata_o),
        .aes_rdata_i  (aes_rdata_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    // AES slave stub: init/next make it busy for 5 cycles; next then raises valid.
    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    acc_t        trace[$];
    logic [31:0] s_key[4];
    logic [31:0] s_blk[4];
    logic [31:0] s_res[4];
    logic        s_enc   = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_pend  = 1'b0;
    int          s_busy  = 0;
    bit          stuck   = 1'b0;

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] b, input logic e);
        if (k == KEY && e && b == PT) return CT;
        if (k == KEY && !e && b == CT) return PT;
        return ~b;
    endfunction

    always_comb begin
        aes_rdata_i = 32'h0;
        if (aes_addr_o == 8'h09) aes_rdata_i = {30'b0, s_valid, (s_busy == 0) && !stuck};
        else if (aes_addr_o[7:4] == 4'h3) aes_rdata_i = s_res[aes_addr_o[1:0]];
    end

    always @(posedge clk_i) begin
        if (aes_cs_o) trace.push_back('{aes_we_o, aes_addr_o, aes_we_o ? aes_wdata_o : aes_rdata_i});
        if (aes_cs_o && aes_we_o) begin
            if (aes_addr_o == 8'h0a) s_enc <= aes_wdata_o[0];
            if (aes_addr_o[7:4] == 4'h1) s_key[aes_addr_o[1:0]] <= aes_wdata_o;
            if (aes_addr_o[7:4] == 4'h2) s_blk[aes_addr_o[1:0]] <= aes_wdata_o;
        end
        if (aes_cs_o && aes_we_o && aes_addr_o == 8'h08) begin
            s_busy  <= 5;
            s_valid <= 1'b0;
            s_pend  <= aes_wdata_o[1];
        end else if (s_busy > 0) begin
            s_busy <= s_busy - 1;
            if (s_busy == 1 && s_pend) begin
                s_valid <= 1'b1;
                s_pend  <= 1'b0;
                {s_res[0], s_res[1], s_res[2], s_res[3]} <=
                    aes_model({s_key[0], s_key[1], s_key[2], s_key[3]},
                              {s_blk[0], s_blk[1], s_blk[2], s_blk[3]}, s_enc);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int count_acc(input logic we, input logic [7:0] lo, input logic [7:0] hi);
        int n = 0;
        foreach (trace[i]) if (trace[i].we == we && trace[i].addr >= lo && trace[i].addr <= hi) n++;
        return n;
    endfunction

    function automatic int count_ctrl(input logic [31:0] val);
        int n = 0;
        foreach (trace[i]) if (trace[i].we && trace[i].addr == 8'h08 && trace[i].data == val) n++;
        return n;
    endfunction

    // Returns at the negedge just after the command handshake edge.
    task automatic start_cmd(input logic [127:0] k, input logic [127:0] b, input logic e);
        int n = 0;
        @(negedge clk_i);
        trace.delete();
        cmd_key_i    = k;
        cmd_block_i  = b;
        cmd_encdec_i = e;
        cmd_valid_i  = 1'b1;
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) check("cmd_accept_wait", 128'(cmd_ready_o), 128'(1'b1));
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    // lat counts clock edges after the handshake edge until res_valid_o is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid_o && lat < 400) begin
            @(negedge clk_i);
            lat++;
        end
        if (!res_valid_o) check("res_wait", 128'(res_valid_o), 128'(1'b1));
    endtask

    task automatic take_result(input string tag, input logic [127:0] exp);
        check(tag, res_data_o, exp);
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        check({tag, "_valid_drop"}, 128'(res_valid_o), 128'(1'b0));
        check({tag, "_ready_back"}, 128'(cmd_ready_o), 128'(1'b1));
    endtask

    task automatic run_cmd(input string tag, input logic [127:0] k, input logic [127:0] b,
                           input logic e, input logic [127:0] exp, output int lat);
        start_cmd(k, b, e);
        wait_result(lat);
        take_result(tag, exp);
    endtask

    logic [8:0] exp_tr[21];
    int         lat;
    int         n;
    bit         seen_valid;

    initial begin
        exp_tr = '{9'h10a, 9'h110, 9'h111, 9'h112, 9'h113, 9'h108, 9'h009, 9'h009, 9'h009,
                   9'h120, 9'h121, 9'h122, 9'h123, 9'h108, 9'h009, 9'h009, 9'h009,
                   9'h030, 9'h031, 9'h032, 9'h033};
        rst_ni       = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_key_i    = '0;
        cmd_block_i  = '0;
        cmd_encdec_i = 1'b0;
        res_ready_i  = 1'b0;
        err_clr_i    = 1'b0;
        #12;
        check("rst_outputs", {123'b0, cmd_ready_o, res_valid_o, busy_o, err_o, aes_cs_o}, 128'(0));
        check("rst_data", res_data_o, 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Encrypt: result, latency 15 + 2*3 + 3 + 3 polls, bus trace order.
        run_cmd("enc", KEY, PT, 1'b1, CT, lat);
        check("enc_latency", 128'(lat), 128'(27));
        check("enc_trace_len", 128'(trace.size()), 128'(21));
        for (int i = 0; i < 21 && i < trace.size(); i++)
            check($sformatf("enc_trace%0d", i), 128'({trace[i].we, trace[i].addr}), 128'(exp_tr[i]));
        if (trace.size() >= 21) begin
            check("enc_cfg_data", 128'(trace[0].data), 128'(32'h1));
            check("enc_key0_data", 128'(trace[1].data), 128'(32'h00010203));
            check("enc_init_data", 128'(trace[5].data), 128'(32'h1));
            check("enc_blk0_data", 128'(trace[9].data), 128'(32'h00112233));
            check("enc_next_data", 128'(trace[13].data), 128'(32'h2));
        end

        // Decrypt.
        run_cmd("dec", KEY, CT, 1'b0, PT, lat);
        check("dec_cfg_data", 128'(trace.size() > 0 ? trace[0].data : 32'hdead), 128'(32'h0));

        // Backpressure, then a back-to-back command in the IDLE cycle.
        start_cmd(KEY, PT, 1'b1);
        wait_result(lat);
        cmd_key_i    = KEY;
        cmd_block_i  = CT;
        cmd_encdec_i = 1'b0;
        cmd_valid_i  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 128'(res_valid_o), 128'(1'b1));
            check("bp_data", res_data_o, CT);
            check("bp_cmd_ready", 128'(cmd_ready_o), 128'(1'b0));
            @(negedge clk_i);
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        check("bp_valid_drop", 128'(res_valid_o), 128'(1'b0));
        check("bp_idle_ready", 128'(cmd_ready_o), 128'(1'b1));
        @(negedge clk_i);
        check("b2b_accepted", 128'({busy_o, cmd_ready_o}), 128'(2'b10));
        cmd_valid_i = 1'b0;
        wait_result(lat);
        take_result("b2b", PT);

        // Poll timeout with STATUS.ready stuck low.
        stuck = 1'b1;
        start_cmd(KEY, PT, 1'b1);
        n = 0;
        seen_valid = 1'b0;
        while (!err_o && n < 300) begin
            if (res_valid_o) seen_valid = 1'b1;
            @(negedge clk_i);
            n++;
        end
        check("to_err", 128'(err_o), 128'(1'b1));
        check("to_polls", 128'(count_acc(1'b0, 8'h09, 8'h09)), 128'(16));
        check("to_no_result_rd", 128'(count_acc(1'b0, 8'h30, 8'h33)), 128'(0));
        check("to_idle", 128'({busy_o, cmd_ready_o, res_valid_o, seen_valid}), 128'(4'b0100));
        @(negedge clk_i);
        check("to_err_sticky", 128'(err_o), 128'(1'b1));
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check("to_err_clr", 128'(err_o), 128'(1'b0));
        stuck = 1'b0;

        // Reset during RESULT2 read, then a fresh command.
        start_cmd(KEY, PT, 1'b1);
        n = 0;
        while (!(aes_cs_o && aes_addr_o == 8'h32) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("rst_reach_rd2", 128'({aes_cs_o, aes_addr_o}), 128'(9'h132));
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_ctrl", 128'({cmd_ready_o, res_valid_o, busy_o, err_o, aes_cs_o, aes_we_o}), 128'(0));
        check("rst_mid_bus", 128'({aes_addr_o, aes_wdata_o}), 128'(0));
        check("rst_mid_data", res_data_o, 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_cmd("post_rst", KEY, PT, 1'b1, CT, lat);

        // Repeated key: cached builds skip CONFIG/KEY/init.
        run_cmd("rep1", KEY, PT, 1'b1, CT, lat);
        run_cmd("rep2", KEY, PT, 1'b1, CT, lat);
        check("rep2_cfg_wr", 128'(count_acc(1'b1, 8'h0a, 8'h0a)), 128'(EXP_CFG_REPEAT));
        check("rep2_key_wr", 128'(count_acc(1'b1, 8'h10, 8'h13)), 128'(EXP_KEY_REPEAT));
        check("rep2_init_wr", 128'(count_ctrl(32'h1)), 128'(EXP_INIT_REPEAT));
        check("rep2_blk_wr", 128'(count_acc(1'b1, 8'h20, 8'h23)), 128'(4));
        run_cmd("rep3", KEY, CT, 1'b0, PT, lat);
        check("rep3_cfg_wr", 128'(count_acc(1'b1, 8'h0a, 8'h0a)), 128'(1));
        check("rep3_key_wr", 128'(count_acc(1'b1, 8'h10, 8'h13)), 128'(4));
        check("rep3_init_wr", 128'(count_ctrl(32'h1)), 128'(1));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
